cmd_readback_burst: RTL and testbench

//  Multi-window shadow store of control-register writes with a single-clock burst readback port.
//  - Captures every parallel command write that hits one of NUM_WIN address windows into dual-port RAM.
//  - RAM address is {window index, low address bits}.
//  - Readback returns a burst of RD_LEN+1 words from the RAM over a valid/ready stream.
//  - Sits beside the command decoder in the mclk domain; feeds a status/debug packetizer.

---
 rtl/cmd_readback_burst_pkg.sv | 41 ++++
 rtl/cmd_readback_burst_if.sv | 30 +++
 rtl/cmd_readback_burst_skid.sv | 50 +++++
 rtl/cmd_readback_burst.sv | 134 +++++++++++++
 tb/tb_cmd_readback_burst.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cmd_readback_burst_pkg.sv
// Shared FSM encoding and helpers for the command readback shadow store.
package cmd_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } rb_state_e;

    localparam int MAX_WIN       = 8;
    localparam int MAX_ADDR_BITS = 32;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Returns {hit, index}; scanning downwards lets the lowest matching window win.
    function automatic logic [3:0] win_match(
        input logic [MAX_ADDR_BITS-1:0]              addr,
        input logic [MAX_WIN-1:0][MAX_ADDR_BITS-1:0] base,
        input logic [MAX_WIN-1:0][MAX_ADDR_BITS-1:0] mask,
        input int                                    num_win
    );
        logic [3:0] res;
        res = '0;
        for (int i = MAX_WIN - 1; i >= 0; i--) begin
            if (i < num_win && ((addr ^ base[i]) & mask[i]) == '0)
                res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/cmd_readback_burst_if.sv
// Command write port plus burst readback stream of the shadow store.
interface cmd_readback_burst_if #(
    parameter int ADDR_BITS  = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RA         = 11,
    parameter int LEN_BITS   = 8
);
    logic [ADDR_BITS-1:0]  par_waddr;
    logic [DATA_WIDTH-1:0] par_data;
    logic                  ad_stb;
    logic                  rd_start;
    logic [RA-1:0]         rd_addr;
    logic [LEN_BITS-1:0]   rd_len;
    logic                  rd_busy;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  rd_written;

    modport master (
        output par_waddr, par_data, ad_stb, rd_start, rd_addr, rd_len, rd_ready,
        input  rd_busy, rd_valid, rd_data, rd_last, rd_written
    );

    modport slave (
        input  par_waddr, par_data, ad_stb, rd_start, rd_addr, rd_len, rd_ready,
        output rd_busy, rd_valid, rd_data, rd_last, rd_written
    );
endinterface

// File: rtl/cmd_readback_burst_skid.sv
// Two-entry valid/ready output buffer for readback words; count feeds the read-issue credit.
module cmd_rb_skid #(
    parameter int W = 32
) (
    input  logic         mclk,
    input  logic         mrst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         in_written,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_written,
    output logic [1:0]   count
);
    localparam int EW = W + 2;

    logic [EW-1:0] slot0, slot1, in_ent;
    logic          pop;

    assign in_ent      = {in_written, in_last, in_data};
    assign out_valid   = (count != 2'd0);
    assign pop         = out_valid && out_ready;
    assign out_data    = slot0[W-1:0];
    assign out_last    = slot0[W] && out_valid;
    assign out_written = slot0[W+1];

    // Upstream only pushes when a slot is free, so push with count==2 and no pop never happens.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            count <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end

        if (pop && count == 2'd2)
            slot0 <= slot1;
        else if (in_valid && (count == 2'd0 || (pop && count == 2'd1)))
            slot0 <= in_ent;

        if (in_valid && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
            slot1 <= in_ent;
    end
endmodule

// File: rtl/cmd_readback_burst.sv
// Windowed shadow RAM of command writes with a burst valid/ready readback port.
// Optional CMD_READBACK_DIRTY_EN adds a written-since-reset bitmap returned as rd_written.
module cmd_readback_burst
    import cmd_readback_pkg::*;
#(
    parameter int                          ADDR_BITS    = 14,
    parameter int                          DATA_WIDTH   = 32,
    parameter int                          NUM_WIN      = 2,
    parameter int                          WIN_LOW_BITS = 10,
    parameter logic [NUM_WIN*ADDR_BITS-1:0] WIN_ADDR    = {14'h0800, 14'h0000},
    parameter logic [NUM_WIN*ADDR_BITS-1:0] WIN_MASK    = {14'h3c00, 14'h3c00},
    parameter int                          LEN_BITS     = 8,
    parameter logic [DATA_WIDTH-1:0]       DEFAULT_DATA = '0
) (
    input logic                mclk,
    input logic                mrst,
    cmd_readback_burst_if.slave bus
);
    localparam int DEPTH = NUM_WIN << WIN_LOW_BITS;
    localparam int RA    = clog2(DEPTH);

    logic [MAX_WIN-1:0][MAX_ADDR_BITS-1:0] win_base, win_mask;
    logic [3:0]            hit;
    logic [RA-1:0]         hit_addr;
    logic                  wr_pend;
    logic [RA-1:0]         wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    always_comb begin
        win_base = '0;
        win_mask = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            win_base[i] = MAX_ADDR_BITS'(WIN_ADDR[i*ADDR_BITS +: ADDR_BITS]);
            win_mask[i] = MAX_ADDR_BITS'(WIN_MASK[i*ADDR_BITS +: ADDR_BITS]);
        end
    end

    assign hit      = win_match(MAX_ADDR_BITS'(bus.par_waddr), win_base, win_mask, NUM_WIN);
    assign hit_addr = RA'((32'(hit[2:0]) << WIN_LOW_BITS) |
                          32'(bus.par_waddr[WIN_LOW_BITS-1:0]));

    always_ff @(posedge mclk) begin
        if (mrst) wr_pend <= 1'b0;
        else      wr_pend <= bus.ad_stb && hit[3];
        wr_addr_q <= hit_addr;
        wr_data_q <= bus.par_data;
    end

    rb_state_e             state;
    logic [RA-1:0]         rd_ptr;
    logic [LEN_BITS-1:0]   rem;
    logic                  busy, infl, infl_last, rd_issue, pop;
    logic [1:0]            sk_cnt;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q, rd_word;
    logic                  rd_wr_flag;

    // Read-first: the registered read samples the array before this edge's write lands.
    always_ff @(posedge mclk) begin
        if (wr_pend)  ram[wr_addr_q] <= wr_data_q;
        if (rd_issue) ram_q <= ram[rd_ptr];
    end

`ifdef CMD_READBACK_DIRTY_EN
    logic [DEPTH-1:0] dirty;
    logic             dirty_q;

    always_ff @(posedge mclk) begin
        if (mrst)         dirty <= '0;
        else if (wr_pend) dirty[wr_addr_q] <= 1'b1;
        if (rd_issue) dirty_q <= dirty[rd_ptr];
    end

    assign rd_word    = dirty_q ? ram_q : DEFAULT_DATA;
    assign rd_wr_flag = dirty_q;
`else
    assign rd_word    = ram_q;
    assign rd_wr_flag = 1'b1;
`endif

    // Credit: buffered words plus the one in the RAM stage must leave a slot after this cycle's pop.
    assign pop      = bus.rd_valid && bus.rd_ready;
    assign rd_issue = (state == ST_BURST) &&
                      (({1'b0, sk_cnt} + {2'b0, infl}) < (3'd2 + {2'b0, pop}));

    always_ff @(posedge mclk) begin
        if (mrst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            infl      <= 1'b0;
            infl_last <= 1'b0;
            rd_ptr    <= '0;
            rem       <= '0;
        end else begin
            infl      <= rd_issue;
            infl_last <= rd_issue && (rem == '0);
            case (state)
                ST_IDLE: if (bus.rd_start) begin
                    rd_ptr <= bus.rd_addr;
                    rem    <= bus.rd_len;
                    state  <= ST_BURST;
                    busy   <= 1'b1;
                end
                ST_BURST: if (rd_issue) begin
                    rd_ptr <= (rd_ptr == RA'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                    rem    <= rem - 1'b1;
                    if (rem == '0) state <= ST_DRAIN;
                end
                ST_DRAIN: if (pop && bus.rd_last) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_busy = busy;

    cmd_rb_skid #(.W(DATA_WIDTH)) u_skid (
        .mclk       (mclk),
        .mrst       (mrst),
        .in_valid   (infl),
        .in_data    (rd_word),
        .in_last    (infl_last),
        .in_written (rd_wr_flag),
        .out_valid  (bus.rd_valid),
        .out_ready  (bus.rd_ready),
        .out_data   (bus.rd_data),
        .out_last   (bus.rd_last),
        .out_written(bus.rd_written),
        .count      (sk_cnt)
    );
endmodule

// File: tb/tb_cmd_readback_burst.sv
// Directed bench for cmd_readback_burst: write/readback table plus burst corner sequences.
module tb_cmd_readback_burst;
    localparam int AB = 14, DW = 32, NW = 2, WLB = 10, LB = 8, DEPTH = 2048, RA = 11;
    localparam logic [DW-1:0] DEF = 32'hDEF0_0DEF;

    logic mclk = 1'b0;
    logic mrst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 mclk = ~mclk;

    cmd_readback_burst_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .RA(RA), .LEN_BITS(LB)) bus ();

    cmd_readback_burst #(
        .ADDR_BITS(AB), .DATA_WIDTH(DW), .NUM_WIN(NW), .WIN_LOW_BITS(WLB),
        .WIN_ADDR({14'h0800, 14'h0000}), .WIN_MASK({14'h3c00, 14'h3c00}),
        .LEN_BITS(LB), .DEFAULT_DATA(DEF)
    ) dut (
        .mclk(mclk),
        .mrst(mrst),
        .bus (bus)
    );

    logic [DW-1:0] mem_m [DEPTH];
    bit            wbit_m [DEPTH];

    typedef struct {
        logic [AB-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [RA-1:0] raddr;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Window 0 covers 0x0000-0x03FF, window 1 covers 0x0800-0x0BFF at RAM 0x400+.
    function automatic void model_wr(input logic [AB-1:0] a, input logic [DW-1:0] d);
        logic [RA-1:0] idx;
        if (a[13:10] == 4'h0)      idx = {1'b0, a[9:0]};
        else if (a[13:10] == 4'h2) idx = {1'b1, a[9:0]};
        else return;
        mem_m[idx]  = d;
        wbit_m[idx] = 1'b1;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [RA-1:0] a);
`ifdef CMD_READBACK_DIRTY_EN
        return wbit_m[a] ? mem_m[a] : DEF;
`else
        return mem_m[a];
`endif
    endfunction

    function automatic logic exp_wr(input logic [RA-1:0] a);
`ifdef CMD_READBACK_DIRTY_EN
        return wbit_m[a];
`else
        return 1'b1;
`endif
    endfunction

    task automatic wr(input logic [AB-1:0] a, input logic [DW-1:0] d);
        @(negedge mclk);
        bus.ad_stb = 1'b1; bus.par_waddr = a; bus.par_data = d;
        @(negedge mclk);
        bus.ad_stb = 1'b0;
        model_wr(a, d);
    endtask

    task automatic burst(input logic [RA-1:0] a, input int len, input int mode, input bit intr,
                         input bit cw, input logic [AB-1:0] cwa, input logic [DW-1:0] cwd,
                         input bit use_tbl, input logic [DW-1:0] tbl_exp);
        int got, k, first, lastk;
        logic [RA-1:0] ea;
        logic [DW-1:0] held_d;
        logic          held_l;
        bit            stalled;
        got = 0; k = 1; first = -1; lastk = -1; ea = a;
        held_d = '0; held_l = 1'b0; stalled = 1'b0;
        @(negedge mclk);
        bus.rd_start = 1'b1; bus.rd_addr = a; bus.rd_len = LB'(len); bus.rd_ready = 1'b0;
        if (cw) begin
            bus.ad_stb = 1'b1; bus.par_waddr = cwa; bus.par_data = cwd;
        end
        @(negedge mclk);
        bus.rd_start = 1'b0; bus.ad_stb = 1'b0;
        chk("busy_after_start", 64'(bus.rd_busy), 64'd1);
        while (got <= len && k < 300) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            if (intr) begin
                bus.rd_start = (k == 2);
                bus.rd_addr  = a + 11'd5;
                bus.rd_len   = 8'd2;
            end
            if (bus.rd_valid) begin
                if (first < 0) first = k;
                if (stalled) begin
                    chk("stall_data_hold", 64'(bus.rd_data), 64'(held_d));
                    chk("stall_last_hold", 64'(bus.rd_last), 64'(held_l));
                end
                if (bus.rd_ready) begin
                    chk("burst_data", 64'(bus.rd_data), 64'(use_tbl ? tbl_exp : exp_data(ea)));
                    chk("burst_last", 64'(bus.rd_last), 64'(got == len));
                    chk("burst_written", 64'(bus.rd_written), 64'(exp_wr(ea)));
                    got++;
                    lastk   = k;
                    ea      = (ea == RA'(DEPTH - 1)) ? '0 : ea + 11'd1;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = bus.rd_data;
                    held_l  = bus.rd_last;
                end
            end
            @(negedge mclk);
            k++;
        end
        bus.rd_ready = 1'b0; bus.rd_start = 1'b0;
        chk("burst_word_count", 64'(got), 64'(len + 1));
        chk("first_valid_latency", 64'(first >= 2), 64'd1);
        if (mode == 0) chk("burst_throughput", 64'(lastk - first), 64'(len));
        chk("busy_drop_after_last", 64'(bus.rd_busy), 64'd0);
        chk("valid_drop_after_last", 64'(bus.rd_valid), 64'd0);
        if (intr) begin
            repeat (4) @(negedge mclk);
            chk("start_while_busy_ignored", 64'({bus.rd_busy, bus.rd_valid}), 64'd0);
        end
        if (cw) model_wr(cwa, cwd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, k;
        bus.par_waddr = '0; bus.par_data = '0; bus.ad_stb = 1'b0;
        bus.rd_start = 1'b0; bus.rd_addr = '0; bus.rd_len = '0; bus.rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0; wbit_m[i] = 1'b0;
        end

        tbl[0] = '{14'h0005, 32'hA5A5_0001, 11'h005, 32'hA5A5_0001};
        tbl[1] = '{14'h0805, 32'h1234_5678, 11'h405, 32'h1234_5678};
        tbl[2] = '{14'h1000, 32'hDEAD_BEEF, 11'h000, 32'hC000_0000};
        tbl[3] = '{14'h0BFF, 32'h5555_AAAA, 11'h7FF, 32'h5555_AAAA};
        tbl[4] = '{14'h3C05, 32'h0BAD_0BAD, 11'h005, 32'hA5A5_0001};
        tbl[5] = '{14'h0403, 32'h0BAD_0403, 11'h003, 32'hC000_0003};

        repeat (3) @(negedge mclk);
        chk("reset_busy", 64'(bus.rd_busy), 64'd0);
        chk("reset_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset_last", 64'(bus.rd_last), 64'd0);
        mrst = 1'b0;

        for (int i = 0; i < 32; i++) wr(14'(i), 32'hC000_0000 + 32'(i));
        wr(14'h0BFE, 32'hD000_07FE);
        wr(14'h0BFF, 32'hD000_07FF);

        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            burst(tbl[i].raddr, 0, 0, 1'b0, 1'b0, '0, '0, 1'b1, tbl[i].exp);
        end

        burst(11'h000, 3, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        burst(11'h7FE, 3, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        burst(11'h010, 15, 1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        burst(11'h000, 3, 0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        burst(11'h007, 0, 0, 1'b0, 1'b1, 14'h0007, 32'h7777_7777, 1'b1, 32'hC000_0007);
        burst(11'h007, 0, 0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h7777_7777);

        // Abort a len-7 burst while its third word is on the port.
        @(negedge mclk);
        bus.rd_start = 1'b1; bus.rd_addr = 11'h010; bus.rd_len = 8'd7; bus.rd_ready = 1'b1;
        @(negedge mclk);
        bus.rd_start = 1'b0;
        got = 0; k = 0;
        while (k < 50 && !(bus.rd_valid && got == 2)) begin
            if (bus.rd_valid) begin
                chk("abort_pre_data", 64'(bus.rd_data), 64'(exp_data(11'h010 + 11'(got))));
                got++;
            end
            @(negedge mclk);
            k++;
        end
        chk("abort_reached_third", 64'(bus.rd_valid && got == 2), 64'd1);
        mrst = 1'b1;
        @(negedge mclk);
        chk("abort_valid", 64'(bus.rd_valid), 64'd0);
        chk("abort_busy", 64'(bus.rd_busy), 64'd0);
        chk("abort_last", 64'(bus.rd_last), 64'd0);
        mrst = 1'b0; bus.rd_ready = 1'b0;
`ifdef CMD_READBACK_DIRTY_EN
        for (int i = 0; i < DEPTH; i++) wbit_m[i] = 1'b0;
`endif
        burst(11'h010, 3, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

`ifdef CMD_READBACK_DIRTY_EN
        burst(11'h009, 0, 0, 1'b0, 1'b0, '0, '0, 1'b1, DEF);
        wr(14'h0009, 32'h0909_0909);
        burst(11'h009, 0, 0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0909_0909);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
